bmp_pixel_packer: RTL and testbench
===================================

Name: bmp_pixel_packer

Overview:
- Synthesizable successor to the bench-side BMP capture logic.
- Accepts a decoded pixel stream after yuv_to_rgb and serialises each pixel into bytes, one channel per cycle.
- Inserts the row padding required for ROW_ALIGN-byte row alignment and generates byte addresses for a frame buffer or BRAM that starts after a fixed header.
- Reports the total file size when the frame completes.
- Generalised in channel count, colour precision, dimensions, address width and row alignment.

Parameters:
- COLOR_PRECISION, 8: bits per channel; must be 8 (byte output).
- NUM_CHANNEL, 3: channels per pixel, 1..4.
- DIM_W, 16: width of the width/height inputs.
- ADDR_W, 20: byte address width.
- HEADER_BYTES, 54: address of the first pixel byte.
- ROW_ALIGN, 4: row stride alignment in bytes; a power of two, 1..8.

Ports:
- r_sysclk  in  1  system clock, rising edge.
- r_arst  in  1  reset, asynchronous, active-high.
- i_start  in  1  one-cycle pulse; latches i_width and i_height and begins a frame.
- i_width  in  DIM_W  pixels per row.
- i_height  in  DIM_W  rows per frame.
- i_de  in  1  pixel valid.
- i_pixel  in  NUM_CHANNEL*8  channel k in bits [8k+7:8k].
- o_ready  out  1  pixel accepted on a cycle where i_de&o_ready.
- o_we  out  1  byte write strobe.
- o_addr  out  ADDR_W  byte address.
- o_byte  out  8  byte data.
- o_done  out  1  level, frame complete.
- o_error  out  1  level, size overflow or zero dimension.
- o_file_size  out  ADDR_W+1  HEADER_BYTES + stride*height; valid while o_done.

Behaviour:
- Interface: reset r_arst, asynchronous, active-high; clock r_sysclk.
- Reset values: all outputs 0; state IDLE; all counters 0.
- Derived values, computed in SETUP:
  - raw = width*NUM_CHANNEL.
  - stride = raw rounded up to a multiple of ROW_ALIGN.
  - pad = stride - raw.
  - size = HEADER_BYTES + stride*height, computed in ADDR_W+1 bits plus one guard bit.
- State machine:
  - IDLE: wait for i_start, latch dimensions, go to SETUP. i_start in any other state except DONE is ignored.
  - SETUP: one cycle. Compute stride, pad and size, and register o_file_size.
    - If width==0 or height==0: o_error=1, go to DONE.
    - If size > 2^ADDR_W: o_error=1, go to DONE, no writes.
    - Otherwise set the row base and go to ACCEPT.
  - ACCEPT: o_ready=1. On i_de, capture i_pixel and go to SER. Not accepted while o_ready=0; upstream holds the data.
  - SER: NUM_CHANNEL cycles, o_we=1, channel 0 first at the lowest address, o_addr incrementing by 1.
    - After the last channel: if x < width-1, x++ and go to ACCEPT.
    - Else if pad > 0, go to PAD.
    - Else go to ROWEND.
  - PAD: pad cycles, o_we=1, o_byte=0x00, continuing addresses.
  - ROWEND: one cycle. x=0, y++, advance the row base.
    - If y==height-1 before the increment, go to DONE.
    - Otherwise go to ACCEPT.
  - DONE: o_done=1 until the next i_start, which clears o_done and o_error and goes to SETUP.
- Latency: pixel accepted at cycle N gives its first byte at N+1.
- Throughput: one pixel per NUM_CHANNEL+1 cycles, plus pad+1 cycles at each row end.
- o_we is never asserted outside SER and PAD.
- The address never exceeds size-1.
- Reset mid-frame: immediate return to IDLE. No further o_we. Frame buffer contents are not cleared.

Optional Feature:
- Macro: BMP_BOTTOM_UP_EN.
- Defined: row y is written at base HEADER_BYTES + (height-1-y)*stride, so the first row received is stored last, matching BMP positive-height order. SETUP computes the top base, and ROWEND subtracts stride from it.
- Undefined: base = HEADER_BYTES + y*stride, top-down; ROWEND adds stride.
- o_file_size is identical in both cases.

Test Plan:
- Top-down, 2x2 frame, NUM_CHANNEL=3, ROW_ALIGN=4, pixels 0x030201, 0x060504, 0x090807, 0x0C0B0A:
  - writes at addresses 54..69 with bytes 01 02 03 04 05 06 00 00 07 08 09 0A 0B 0C 00 00;
  - o_done=1, o_file_size=70.
- Top-down, 4x1 frame: 12 bytes at 54..65, no PAD cycles, o_file_size=66.
- Same 2x2 stimulus with BMP_BOTTOM_UP_EN defined:
  - row 0 bytes at 62..69, row 1 bytes at 54..61;
  - o_file_size=70.
- Zero dimension and overflow:
  - i_width=0: o_error=1, o_done=1, no o_we, o_file_size=54.
  - ADDR_W=8, 16x16 frame: o_error=1, no writes.
- Control robustness:
  - i_start pulsed mid-frame: ignored, addresses unchanged.
  - i_de held low for 10 cycles in ACCEPT: no o_we, and o_ready stays 1 throughout.
- r_arst asserted during SER: o_we drops at the same edge, all outputs return to 0; a new 2x2 frame then completes correctly.

Source files
------------

// File: rtl/bmp_pixel_packer.sv
`default_nettype none
// ============================================================================
// Module  : bmp_pixel_packer
// Purpose : Serialises pixels into padded BMP rows with frame-buffer byte
//           addresses. Define BMP_BOTTOM_UP_EN to store rows bottom-up.
// Revision: 1.0 - initial release
// ============================================================================
module bmp_pixel_packer #(
   parameter int COLOR_PRECISION = 8,
   parameter int NUM_CHANNEL     = 3,
   parameter int DIM_W           = 16,
   parameter int ADDR_W          = 20,
   parameter int HEADER_BYTES    = 54,
   parameter int ROW_ALIGN       = 4
) (
   input  logic                                   r_sysclk,
   input  logic                                   r_arst,
   input  logic                                   i_start,
   input  logic [DIM_W-1:0]                       i_width,
   input  logic [DIM_W-1:0]                       i_height,
   input  logic                                   i_de,
   input  logic [NUM_CHANNEL*COLOR_PRECISION-1:0] i_pixel,
   output logic                                   o_ready,
   output logic                                   o_we,
   output logic [ADDR_W-1:0]                      o_addr,
   output logic [7:0]                             o_byte,
   output logic                                   o_done,
   output logic                                   o_error,
   output logic [ADDR_W:0]                        o_file_size
);

   localparam int PIX_W  = NUM_CHANNEL * COLOR_PRECISION;
   localparam int RAW_W  = DIM_W + 3;
   localparam int PROD_W = RAW_W + DIM_W;
   localparam int SIZE_W = ((PROD_W > ADDR_W + 1) ? PROD_W : ADDR_W + 1) + 1;
   localparam int CH_W   = $clog2(NUM_CHANNEL + 1);
   localparam int PAD_W  = 4;
   localparam logic [RAW_W-1:0] C_ALIGN_MASK = ~RAW_W'(ROW_ALIGN - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_ACCEPT, S_SER, S_PAD, S_ROWEND, S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [DIM_W-1:0]    width_q, width_d, height_q, height_d;
   logic [DIM_W-1:0]    x_q, x_d, y_q, y_d;
   logic [CH_W-1:0]     ch_q, ch_d;
   logic [PAD_W-1:0]    pad_q, pad_d, pad_cnt_q, pad_cnt_d;
   logic [RAW_W-1:0]    stride_q, stride_d;
   logic [PIX_W-1:0]    pix_q, pix_d;
   logic [ADDR_W-1:0]   base_q, base_d, wptr_q, wptr_d;
   logic                ready_q, ready_d, we_q, we_d, done_q, done_d, error_q, error_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [7:0]          byte_q, byte_d;
   logic [ADDR_W:0]     file_size_q, file_size_d;

   // Size is evaluated at full product width so oversize frames cannot wrap.
   logic [RAW_W-1:0]    w_raw, w_stride;
   logic [PAD_W-1:0]    w_pad;
   logic [SIZE_W-1:0]   w_size;
   logic                w_overflow;

   assign w_raw      = RAW_W'(width_q) * RAW_W'(NUM_CHANNEL);
   assign w_stride   = (w_raw + RAW_W'(ROW_ALIGN - 1)) & C_ALIGN_MASK;
   assign w_pad      = PAD_W'(w_stride - w_raw);
   assign w_size     = SIZE_W'(HEADER_BYTES) + SIZE_W'(w_stride) * SIZE_W'(height_q);
   assign w_overflow = w_size > (SIZE_W'(1) << ADDR_W);

   always_comb begin
      state_d     = state_q;
      width_d     = width_q;
      height_d    = height_q;
      x_d         = x_q;
      y_d         = y_q;
      ch_d        = ch_q;
      pad_d       = pad_q;
      pad_cnt_d   = pad_cnt_q;
      stride_d    = stride_q;
      pix_d       = pix_q;
      base_d      = base_q;
      wptr_d      = wptr_q;
      ready_d     = 1'b0;
      we_d        = 1'b0;
      done_d      = done_q;
      error_d     = error_q;
      addr_d      = addr_q;
      byte_d      = byte_q;
      file_size_d = file_size_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (i_start) begin
               width_d  = i_width;
               height_d = i_height;
               done_d   = 1'b0;
               error_d  = 1'b0;
               state_d  = S_SETUP;
            end
         end
         S_SETUP: begin
            stride_d    = w_stride;
            pad_d       = w_pad;
            file_size_d = w_size[ADDR_W:0];
            x_d         = '0;
            y_d         = '0;
            if (width_q == '0 || height_q == '0 || w_overflow) begin
               error_d = 1'b1;
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
`ifdef BMP_BOTTOM_UP_EN
               base_d = ADDR_W'(w_size - SIZE_W'(w_stride));
`else
               base_d = ADDR_W'(HEADER_BYTES);
`endif
               wptr_d  = base_d;
               ready_d = 1'b1;
               state_d = S_ACCEPT;
            end
         end
         S_ACCEPT: begin
            if (i_de) begin
               we_d    = 1'b1;
               byte_d  = i_pixel[7:0];
               pix_d   = i_pixel >> COLOR_PRECISION;
               addr_d  = wptr_q;
               wptr_d  = wptr_q + ADDR_W'(1);
               ch_d    = CH_W'(1);
               state_d = S_SER;
            end else begin
               ready_d = 1'b1;
            end
         end
         S_SER: begin
            if (ch_q != CH_W'(NUM_CHANNEL)) begin
               we_d   = 1'b1;
               byte_d = pix_q[7:0];
               pix_d  = pix_q >> COLOR_PRECISION;
               addr_d = wptr_q;
               wptr_d = wptr_q + ADDR_W'(1);
               ch_d   = ch_q + CH_W'(1);
            end else if ((x_q + DIM_W'(1)) < width_q) begin
               x_d     = x_q + DIM_W'(1);
               ready_d = 1'b1;
               state_d = S_ACCEPT;
            end else if (pad_q != '0) begin
               we_d      = 1'b1;
               byte_d    = 8'h00;
               addr_d    = wptr_q;
               wptr_d    = wptr_q + ADDR_W'(1);
               pad_cnt_d = PAD_W'(1);
               state_d   = S_PAD;
            end else begin
               state_d = S_ROWEND;
            end
         end
         S_PAD: begin
            if (pad_cnt_q != pad_q) begin
               we_d      = 1'b1;
               byte_d    = 8'h00;
               addr_d    = wptr_q;
               wptr_d    = wptr_q + ADDR_W'(1);
               pad_cnt_d = pad_cnt_q + PAD_W'(1);
            end else begin
               state_d = S_ROWEND;
            end
         end
         S_ROWEND: begin
            x_d = '0;
            y_d = y_q + DIM_W'(1);
`ifdef BMP_BOTTOM_UP_EN
            base_d = base_q - ADDR_W'(stride_q);
`else
            base_d = base_q + ADDR_W'(stride_q);
`endif
            wptr_d = base_d;
            if (y_q == height_q - DIM_W'(1)) begin
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               ready_d = 1'b1;
               state_d = S_ACCEPT;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge r_sysclk or posedge r_arst) begin
      if (r_arst) begin
         state_q     <= S_IDLE;
         width_q     <= '0;
         height_q    <= '0;
         x_q         <= '0;
         y_q         <= '0;
         ch_q        <= '0;
         pad_q       <= '0;
         pad_cnt_q   <= '0;
         stride_q    <= '0;
         pix_q       <= '0;
         base_q      <= '0;
         wptr_q      <= '0;
         ready_q     <= 1'b0;
         we_q        <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         addr_q      <= '0;
         byte_q      <= '0;
         file_size_q <= '0;
      end else begin
         state_q     <= state_d;
         width_q     <= width_d;
         height_q    <= height_d;
         x_q         <= x_d;
         y_q         <= y_d;
         ch_q        <= ch_d;
         pad_q       <= pad_d;
         pad_cnt_q   <= pad_cnt_d;
         stride_q    <= stride_d;
         pix_q       <= pix_d;
         base_q      <= base_d;
         wptr_q      <= wptr_d;
         ready_q     <= ready_d;
         we_q        <= we_d;
         done_q      <= done_d;
         error_q     <= error_d;
         addr_q      <= addr_d;
         byte_q      <= byte_d;
         file_size_q <= file_size_d;
      end
   end

   assign o_ready     = ready_q;
   assign o_we        = we_q;
   assign o_addr      = addr_q;
   assign o_byte      = byte_q;
   assign o_done      = done_q;
   assign o_error     = error_q;
   assign o_file_size = file_size_q;

endmodule
`default_nettype wire

// File: tb/tb_bmp_pixel_packer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_bmp_pixel_packer
// Purpose : Directed self-checking bench for bmp_pixel_packer.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bmp_pixel_packer;

   logic        clk = 1'b0;
   logic        arst = 1'b1;
   always #5 clk = ~clk;

   logic        start = 1'b0, de = 1'b0;
   logic [15:0] width = '0, height = '0;
   logic [23:0] pixel = '0;
   logic        ready, we, done, err;
   logic [19:0] addr;
   logic [7:0]  byt;
   logic [20:0] fsize;

   logic        start2 = 1'b0, de2 = 1'b0;
   logic [15:0] width2 = '0, height2 = '0;
   logic [23:0] pixel2 = '0;
   logic        ready2, we2, done2, err2;
   logic [7:0]  addr2, byt2;
   logic [8:0]  fsize2;

   bmp_pixel_packer dut (
      .r_sysclk(clk), .r_arst(arst), .i_start(start), .i_width(width), .i_height(height),
      .i_de(de), .i_pixel(pixel), .o_ready(ready), .o_we(we), .o_addr(addr), .o_byte(byt),
      .o_done(done), .o_error(err), .o_file_size(fsize));

   bmp_pixel_packer #(.ADDR_W(8)) dut_small (
      .r_sysclk(clk), .r_arst(arst), .i_start(start2), .i_width(width2), .i_height(height2),
      .i_de(de2), .i_pixel(pixel2), .o_ready(ready2), .o_we(we2), .o_addr(addr2), .o_byte(byt2),
      .o_done(done2), .o_error(err2), .o_file_size(fsize2));

   typedef struct { int a; int b; int c; } wr_t;
   wr_t  log_q[$];
   wr_t  ent;
   int   cyc = 0;
   int   we2_cnt = 0;
   int   first_de_cyc = 0;
   int   n_cmp = 0, n_err = 0;

   logic [23:0] pix_tab [4] = '{24'h030201, 24'h060504, 24'h090807, 24'h0C0B0A};
   int          exp_b   [16] = '{1, 2, 3, 4, 5, 6, 0, 0, 7, 8, 9, 10, 11, 12, 0, 0};

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (we === 1'b1) begin
         ent.a = int'(addr);
         ent.b = int'(byt);
         ent.c = cyc;
         log_q.push_back(ent);
      end
      if (we2 === 1'b1) we2_cnt++;
   end

   function automatic int exp_a2x2(input int i);
`ifdef BMP_BOTTOM_UP_EN
      return (i < 8) ? 62 + i : 46 + i;
`else
      return 54 + i;
`endif
   endfunction

   task automatic start_frame(input int w, input int h);
      @(negedge clk);
      width = 16'(w); height = 16'(h); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic feed_pixels(input int from, input int to, input int glitch);
      int t;
      for (int p = from; p < to; p++) begin
         t = 0;
         while (ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
         if (ready !== 1'b1) begin
            n_cmp++; n_err++;
            $display("FAIL ready_timeout pixel %0d: o_ready=%b required 1", p, ready);
            return;
         end
         if (p == 0) first_de_cyc = cyc;
         de = 1'b1; pixel = pix_tab[p];
         if (p == glitch) begin start = 1'b1; width = 16'd5; end
         @(negedge clk);
         de = 1'b0; start = 1'b0;
      end
   endtask

   task automatic wait_done();
      int t = 0;
      while (done !== 1'b1 && t < 200) begin @(negedge clk); t++; end
      n_cmp++;
      if (done !== 1'b1) begin
         n_err++;
         $display("FAIL done_timeout: o_done=%b required 1", done);
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({ready, we, done, err} !== 4'b0000) begin
         n_err++; $display("FAIL reset_flags: got %b required 0000", {ready, we, done, err});
      end
      n_cmp++;
      if (addr !== '0 || byt !== '0) begin
         n_err++; $display("FAIL reset_addr_byte: got %0d/%0d required 0/0", addr, byt);
      end
      n_cmp++;
      if (fsize !== '0) begin
         n_err++; $display("FAIL reset_file_size: got %0d required 0", fsize);
      end
      arst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_frame_2x2(input string tag, input int glitch);
      log_q.delete();
      start_frame(2, 2);
      feed_pixels(0, 4, glitch);
      wait_done();
      n_cmp++;
      if (log_q.size() != 16) begin
         n_err++; $display("FAIL %s_count: got %0d writes required 16", tag, log_q.size());
      end else begin
         for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (log_q[i].a != exp_a2x2(i) || log_q[i].b != exp_b[i]) begin
               n_err++;
               $display("FAIL %s_byte%0d: got addr %0d data %02h required addr %0d data %02h",
                        tag, i, log_q[i].a, log_q[i].b, exp_a2x2(i), exp_b[i]);
            end
         end
         n_cmp++;
         if (log_q[0].c != first_de_cyc + 1) begin
            n_err++; $display("FAIL %s_latency: first byte cycle %0d required %0d",
                              tag, log_q[0].c, first_de_cyc + 1);
         end
      end
      n_cmp++;
      if (fsize !== 21'd70 || err !== 1'b0 || done !== 1'b1) begin
         n_err++; $display("FAIL %s_status: size %0d err %b done %b required 70 0 1",
                           tag, fsize, err, done);
      end
   endtask

   task automatic test_frame_4x1();
      log_q.delete();
      start_frame(4, 1);
      feed_pixels(0, 4, -1);
      wait_done();
      n_cmp++;
      if (log_q.size() != 12) begin
         n_err++; $display("FAIL 4x1_count: got %0d writes required 12", log_q.size());
      end else begin
         for (int i = 0; i < 12; i++) begin
            n_cmp++;
            if (log_q[i].a != 54 + i || log_q[i].b != i + 1) begin
               n_err++; $display("FAIL 4x1_byte%0d: got addr %0d data %02h required addr %0d data %02h",
                                 i, log_q[i].a, log_q[i].b, 54 + i, i + 1);
            end
         end
         // Four pixels at one per four cycles with no pad: 14 cycles first to last byte.
         n_cmp++;
         if (log_q[11].c - log_q[0].c != 14) begin
            n_err++; $display("FAIL 4x1_span: got %0d cycles required 14", log_q[11].c - log_q[0].c);
         end
      end
      n_cmp++;
      if (fsize !== 21'd66 || err !== 1'b0) begin
         n_err++; $display("FAIL 4x1_status: size %0d err %b required 66 0", fsize, err);
      end
   endtask

   task automatic test_zero_dim();
      log_q.delete();
      start_frame(0, 2);
      wait_done();
      n_cmp++;
      if (err !== 1'b1 || done !== 1'b1 || fsize !== 21'd54) begin
         n_err++; $display("FAIL zero_dim_status: err %b done %b size %0d required 1 1 54", err, done, fsize);
      end
      n_cmp++;
      if (log_q.size() != 0) begin
         n_err++; $display("FAIL zero_dim_writes: got %0d required 0", log_q.size());
      end
   endtask

   task automatic test_overflow();
      int t = 0;
      @(negedge clk);
      width2 = 16'd16; height2 = 16'd16; start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      while (done2 !== 1'b1 && t < 50) begin @(negedge clk); t++; end
      repeat (4) @(negedge clk);
      n_cmp++;
      if (err2 !== 1'b1 || done2 !== 1'b1) begin
         n_err++; $display("FAIL overflow_status: err %b done %b required 1 1", err2, done2);
      end
      n_cmp++;
      if (we2_cnt != 0) begin
         n_err++; $display("FAIL overflow_writes: got %0d required 0", we2_cnt);
      end
   endtask

   task automatic test_de_idle();
      int t = 0;
      log_q.delete();
      start_frame(2, 2);
      while (ready !== 1'b1 && t < 20) begin @(negedge clk); t++; end
      for (int s = 0; s < 10; s++) begin
         n_cmp++;
         if (ready !== 1'b1 || we !== 1'b0) begin
            n_err++; $display("FAIL de_idle_cycle%0d: ready %b we %b required 1 0", s, ready, we);
         end
         @(negedge clk);
      end
      feed_pixels(0, 4, -1);
      wait_done();
      n_cmp++;
      if (log_q.size() != 16 || fsize !== 21'd70) begin
         n_err++; $display("FAIL de_idle_frame: writes %0d size %0d required 16 70", log_q.size(), fsize);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      log_q.delete();
      start_frame(2, 2);
      feed_pixels(0, 1, -1);
      n_cmp++;
      if (we !== 1'b1) begin
         n_err++; $display("FAIL mid_reset_in_ser: we %b required 1", we);
      end
      #1 arst = 1'b1;
      #1;
      n_cmp++;
      if ({ready, we, done, err} !== 4'b0000 || addr !== '0 || byt !== '0 || fsize !== '0) begin
         n_err++; $display("FAIL mid_reset_outputs: flags %b addr %0d byte %0d size %0d required all 0",
                           {ready, we, done, err}, addr, byt, fsize);
      end
      n = log_q.size();
      repeat (3) @(negedge clk);
      n_cmp++;
      if (log_q.size() != n) begin
         n_err++; $display("FAIL mid_reset_we: got %0d extra writes required 0", log_q.size() - n);
      end
      arst = 1'b0;
      @(negedge clk);
      test_frame_2x2("after_reset", -1);
   endtask

   initial begin
      test_reset();
      test_frame_2x2("frame2x2", -1);
      test_frame_4x1();
      test_zero_dim();
      test_overflow();
      test_frame_2x2("start_glitch", 1);
      test_de_idle();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
